// File: rtl/cgra_config_loader.sv
// cgra_config_loader: streams num_words consecutive 64-bit config words from the
// CGRA config memory (1-cycle read latency) through a credit-managed capture FIFO
// onto a valid/ready stream tagged with the word index.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, base_addr, num_words load request (accepted only when idle)
//   busy, done                 load in progress / one-cycle completion pulse
//   cfg_addr, cfg_ren          registered read request to config memory
//   cfg_rdata, cfg_valid       read response, one cycle after the request is sampled
//   out_valid, out_ready       output handshake
//   out_data, out_idx          FIFO head word and its 0-based index in the load
//   cfg_checksum               XOR of all words popped in the current load
//                              (only with CGRA_CFG_LOADER_CHECKSUM_EN defined)
module cgra_config_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic                  cfg_ren,
    input  logic [DATA_WIDTH-1:0] cfg_rdata,
    input  logic                  cfg_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_idx
`ifdef CGRA_CFG_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] cfg_checksum
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d, addr_q, addr_d;
    logic [CNT_WIDTH-1:0]    num_q, num_d, issued_q, issued_d, idx_q, idx_d;
    logic [1:0]              pend_q, pend_d;
    logic                    ren_q, ren_d;
    logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic                    push, pop, accept;
    logic [PW+1:0]           credit;
    assign accept = state_q == IDLE && start;
    // responses outside a load are stale (e.g. in flight across a reset) and dropped
    assign push   = cfg_valid && (state_q == FETCH || state_q == DRAIN);
    assign pop    = out_valid && out_ready;
    // pend counts every read from the moment it is issued until it is captured,
    // so FIFO occupancy plus pend bounds what can still land in the FIFO
    assign credit = (PW+2)'(cnt_q) + (PW+2)'(pend_q);
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        num_d    = num_q;
        issued_d = issued_q;
        addr_d   = addr_q;
        ren_d    = 1'b0;
        idx_d    = idx_q + CNT_WIDTH'(pop);
        wp_d     = wp_q + PW'(push);
        rp_d     = rp_q + PW'(pop);
        cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        case (state_q)
            IDLE: if (start) begin
                base_d   = base_addr & ~ADDR_WIDTH'(7);
                num_d    = num_words;
                issued_d = '0;
                idx_d    = '0;
                state_d  = num_words == '0 ? DONE : FETCH;
            end
            FETCH: if (issued_q < num_q && credit < (PW+2)'(FIFO_DEPTH)) begin
                ren_d    = 1'b1;
                addr_d   = base_q + ADDR_WIDTH'({issued_q, 3'b000});
                issued_d = issued_q + CNT_WIDTH'(1);
                if (issued_d == num_q) state_d = DRAIN;
            end
            DRAIN: if (pend_q == '0 && cnt_q == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
        pend_d = accept ? 2'b00 : pend_q + 2'(ren_d) - 2'(push);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            issued_q <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            ren_q    <= 1'b0;
            pend_q   <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            ren_q    <= ren_d;
            pend_q   <= pend_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= cfg_rdata;
    end
    assign busy      = state_q == FETCH || state_q == DRAIN;
    assign done      = state_q == DONE;
    assign cfg_addr  = addr_q;
    assign cfg_ren   = ren_q;
    assign out_valid = cnt_q != '0;
    // storage is not reset, so the head is masked to keep out_data at 0 when empty
    assign out_data  = out_valid ? mem_q[rp_q] : '0;
    assign out_idx   = idx_q;
`ifdef CGRA_CFG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] ck_q;
    always_ff @(posedge clk) begin
        if (!rst_n || accept) ck_q <= '0;
        else if (pop) ck_q <= ck_q ^ out_data;
    end
    assign cfg_checksum = ck_q;
`endif
endmodule

// File: tb/tb_cgra_config_loader.sv
// tb_cgra_config_loader: randomized scoreboard bench with a behavioural memory and loader model
module tb_cgra_config_loader;
    localparam int DW = 64, AW = 32, CW = 16, D = 4;
    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_words = '0;
    logic          busy, done, cfg_ren, out_valid;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_rdata = '0, out_data;
    logic          cfg_valid = 1'b0, out_ready = 1'b0;
    logic [CW-1:0] out_idx;
`ifdef CGRA_CFG_LOADER_CHECKSUM_EN
    logic [DW-1:0] cfg_checksum;
`endif
    cgra_config_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .cfg_addr(cfg_addr), .cfg_ren(cfg_ren),
        .cfg_rdata(cfg_rdata), .cfg_valid(cfg_valid), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
`ifdef CGRA_CFG_LOADER_CHECKSUM_EN
        , .cfg_checksum(cfg_checksum)
`endif
    );
    always #5 clk = ~clk;
    typedef struct packed {logic [DW-1:0] d; logic [CW-1:0] i;} exp_t;
    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            checks = 0, errors = 0, mem_mode = 0, ready_mode = 0, rph = 0;
    int            rens = 0, pops = 0, done_cnt = 0;
    bit            mon_en = 0, stale_inj = 0, prev_stall = 0;
    logic [31:0]   salt = '0;
    logic [DW-1:0] prev_data = '0, ck_exp = '0;
    logic [CW-1:0] prev_idx = '0;

    function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
        if (mem_mode == 0) return 64'hA5A5_0000_0000_0000 + DW'((a - 32'h100) >> 3);
        if (mem_mode == 2) return DW'(1) << ((a - 32'h200) >> 3);
        return {salt, a};
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, expv);
        end
    endtask

    // config memory: one-cycle registered read, plus optional stale response injection
    initial forever begin
        @(posedge clk);
        cfg_valid <= cfg_ren | stale_inj;
        cfg_rdata <= stale_inj ? 64'hDEAD_BEEF_DEAD_BEEF : mem_word(cfg_addr);
    end

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (rph == 0) : 1'($urandom_range(0, 1));
        rph = (rph + 1) % 4;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cfg_ren) begin
                    rens++;
                    chk("ren_expected", addr_q.size() != 0, 1);
                    if (addr_q.size() != 0) chk("cfg_addr", cfg_addr, addr_q.pop_front());
                    chk("credit_limit", (rens - pops) <= D, 1);
                end
                if (prev_stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, prev_data);
                    chk("hold_idx", out_idx, prev_idx);
                end
                if (out_valid && out_ready) begin
                    pops++;
                    chk("pop_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_idx", out_idx, e.i);
                    end
                end
                if (done) done_cnt++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_idx   = out_idx;
            end
        end
    end

    task automatic start_load(logic [AW-1:0] b, logic [CW-1:0] n);
        logic [AW-1:0] a;
        @(negedge clk);
        ck_exp = '0;
        for (int i = 0; i < int'(n); i++) begin
            a = (b & ~32'h7) + 32'(i) * 8;
            addr_q.push_back(a);
            exp_q.push_back('{d: mem_word(a), i: CW'(i)});
            ck_exp ^= mem_word(a);
        end
        done_cnt  = 0;
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_load();
        bit seen;
        seen = done;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", seen, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
        chk("done_once", done_cnt, 1);
        chk("words_left", exp_q.size(), 0);
        chk("addrs_left", addr_q.size(), 0);
`ifdef CGRA_CFG_LOADER_CHECKSUM_EN
        chk("checksum", cfg_checksum, ck_exp);
`endif
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_ren", cfg_ren, 0);
        chk("rst_cfg_addr", cfg_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
`ifdef CGRA_CFG_LOADER_CHECKSUM_EN
        chk("rst_checksum", cfg_checksum, 0);
`endif
    endtask

    initial begin
        int d, n;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        mem_mode   = 0;
        ready_mode = 0;
        start_load(32'h100, 8);
        chk("busy_in_load", busy, 1);
        d = 0;
        while (!out_valid && d < 10) begin
            @(negedge clk);
            d++;
        end
        chk("first_valid_latency", d, 3);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(out_valid);
            @(negedge clk);
        end
        chk("burst_len", n, 8);
        finish_load();
        ready_mode = 1;
        start_load(32'h1000, 16);
        finish_load();
        ready_mode = 0;
        start_load(32'h40, 0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        finish_load();
        mem_mode = 1;
        salt     = $urandom;
        start_load(32'hFFFF_FFFB, 2);
        finish_load();
        ready_mode = 2;
        start_load(32'h2000, 12);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 32'h5000;
        num_words = 3;
        @(negedge clk);
        start = 1'b0;
        finish_load();
        ready_mode = 1;
        start_load(32'h3000, 20);
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        exp_q.delete();
        addr_q.delete();
        prev_stall = 1'b0;
        done_cnt   = 0;
        rens       = 0;
        pops       = 0;
        rst_n      = 1'b1;
        mon_en     = 1'b1;
        stale_inj  = 1'b1;
        @(negedge clk);
        stale_inj = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stale_out_valid", out_valid, 0);
            chk("stale_busy", busy, 0);
        end
        ready_mode = 0;
        start_load(32'h3000, 5);
        finish_load();
`ifdef CGRA_CFG_LOADER_CHECKSUM_EN
        mem_mode = 2;
        start_load(32'h200, 3);
        finish_load();
        chk("checksum_124", cfg_checksum, 64'h7);
        start_load(32'h200, 3);
        chk("checksum_cleared", cfg_checksum, 0);
        finish_load();
`endif
        mem_mode = 1;
        for (int k = 0; k < 10; k++) begin
            salt       = $urandom;
            ready_mode = $urandom_range(0, 2);
            start_load($urandom, CW'($urandom_range(0, 20)));
            finish_load();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
